// File: rtl/wb_cache_control.sv
// Write-back set-associative cache controller: hit/miss FSM, tree-PLRU replacement, hit/miss counters.
// Latency: a hit gives mem_resp in the CHECK cycle right after the request is sampled; a miss adds WRITEBACK/FILL.
// Backpressure: the CPU holds its request until mem_resp; WRITEBACK/FILL hold their request until pmem_resp.
module wb_cache_control #(
  parameter int WAYS   = 4,
  parameter int SETS   = 16,
  parameter int PERF_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [$clog2(SETS)-1:0]  set_idx,
  input  logic [WAYS-1:0]          hit_vec,
  input  logic [WAYS-1:0]          valid_vec,
  input  logic [WAYS-1:0]          dirty_vec,
  input  logic                     pmem_resp,
  input  logic                     clr_cnt,
  output logic                     mem_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [$clog2(WAYS)-1:0]  way_sel,
  output logic                     load_tag,
  output logic                     load_data,
  output logic                     set_dirty,
  output logic                     clr_dirty,
  output logic                     addr_sel_wb,
  output logic [PERF_W-1:0]        hit_cnt,
  output logic [PERF_W-1:0]        miss_cnt
);
  localparam int WW = $clog2(WAYS);
  localparam int PW = WAYS - 1;

  typedef enum logic [1:0] {IDLE, CHECK, WRITEBACK, FILL} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] victim_q, victim_d;
  logic [PW-1:0] plru_q [SETS];
  logic          refill_q;

  logic [WAYS-1:0] hit_mask;
  logic            hit;
  logic            inv_any;
  logic [WW-1:0]   hit_way;
  logic [WW-1:0]   inv_way;
  logic [WW-1:0]   plru_way;
  logic [PW-1:0]   plru_upd;
  logic            plru_we;
  logic            count_hit;
  logic            count_miss;

  // Lookup: lowest-index hit, lowest-index invalid way, PLRU victim walk and the PLRU update for the hit way.
  always_comb begin
    logic [PW-1:0] cur;
    int            node;
    logic          b;
    logic          d;
    hit_mask = hit_vec & valid_vec;
    hit      = |hit_mask;
    inv_any  = ~&valid_vec;
    hit_way  = '0;
    inv_way  = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_mask[i])   hit_way = WW'(i);
      if (!valid_vec[i]) inv_way = WW'(i);
    end
    cur      = plru_q[set_idx];
    // Walk root to leaf: a 0 bit steers to the lower half, a 1 bit to the upper half.
    plru_way = '0;
    node     = 0;
    for (int l = 0; l < WW; l++) begin
      b = 1'b0;
      for (int n = 0; n < PW; n++) if (n == node) b = cur[n];
      plru_way[WW-1-l] = b;
      node = 2 * node + 1 + int'(b);
    end
    // Point every node on the hit way's path at the other subtree.
    plru_upd = cur;
    node     = 0;
    for (int l = 0; l < WW; l++) begin
      d = hit_way[WW-1-l];
      for (int n = 0; n < PW; n++) if (n == node) plru_upd[n] = ~d;
      node = 2 * node + 1 + int'(d);
    end
  end

  // Next state and strobes; way_sel parks on the latched victim outside a CHECK hit.
  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    load_tag    = 1'b0;
    load_data   = 1'b0;
    set_dirty   = 1'b0;
    clr_dirty   = 1'b0;
    addr_sel_wb = 1'b0;
    way_sel     = victim_q;
    plru_we     = 1'b0;
    count_hit   = 1'b0;
    count_miss  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) state_d = CHECK;
      end
      CHECK: begin
        if (hit) begin
          mem_resp  = 1'b1;
          way_sel   = hit_way;
          plru_we   = 1'b1;
          // A simultaneous read+write is served as a write.
          load_data = mem_write;
          set_dirty = mem_write;
          count_hit = !refill_q;
          state_d   = IDLE;
        end else begin
          victim_d   = inv_any ? inv_way : plru_way;
          count_miss = !refill_q;
          state_d    = (valid_vec[victim_d] && dirty_vec[victim_d]) ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        pmem_write  = 1'b1;
        addr_sel_wb = 1'b1;
        if (pmem_resp) begin
          clr_dirty = 1'b1;
          state_d   = FILL;
        end
      end
      FILL: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_tag  = 1'b1;
          load_data = 1'b1;
          state_d   = CHECK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, victim and the "this CHECK follows a FILL" marker that keeps re-checks out of the counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      refill_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      refill_q <= (state_q == FILL);
    end
  end

  // Per-set PLRU bits, updated on every CHECK hit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (plru_we) begin
      plru_q[set_idx] <= plru_upd;
    end
  end

  // Saturating hit/miss counters; clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (clr_cnt) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (count_hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
      if (count_miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_cache_control.sv
// Bench for wb_cache_control: acts as CPU, tag/data datapath and memory around the controller.
// Expected responses are queued at issue time from a behavioural cache model and popped by a monitor on mem_resp.
// Memory latency and spurious pmem_resp are randomized; every wait is bounded.
module tb_wb_cache_control;
  localparam int WAYS   = 4;
  localparam int SETS   = 16;
  localparam int PERF_W = 4;
  localparam int MAXC   = (1 << PERF_W) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [3:0]  set_idx;
  logic [3:0]  hit_vec;
  logic [3:0]  valid_vec;
  logic [3:0]  dirty_vec;
  logic        pmem_resp = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        mem_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [1:0]  way_sel;
  logic        load_tag;
  logic        load_data;
  logic        set_dirty;
  logic        clr_dirty;
  logic        addr_sel_wb;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;

  wb_cache_control #(.WAYS(WAYS), .SETS(SETS), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .set_idx(set_idx),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .pmem_resp(pmem_resp),
    .clr_cnt(clr_cnt), .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .way_sel(way_sel), .load_tag(load_tag), .load_data(load_data), .set_dirty(set_dirty),
    .clr_dirty(clr_dirty), .addr_sel_wb(addr_sel_wb), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit hit;
    bit wr;
    bit wb;
    int way;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   nchk = 0;
  int   nerr = 0;

  // Datapath state, changed only by the controller's strobes.
  int   dp_tag   [SETS][WAYS];
  bit   dp_valid [SETS][WAYS];
  bit   dp_dirty [SETS][WAYS];
  // Reference cache model, changed only at issue time.
  int     m_tag   [SETS][WAYS];
  bit     m_valid [SETS][WAYS];
  bit     m_dirty [SETS][WAYS];
  bit [2:0] m_plru [SETS];
  int     m_hit = 0;
  int     m_miss = 0;

  int cur_set = 0;
  int cur_tag = 0;
  bit mem_en = 1'b0;
  bit resp_seen = 1'b0;
  bit saw_wb = 1'b0;
  bit saw_fill = 1'b0;
  bit last_resp = 1'b0;
  int mem_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Tree PLRU for four ways: b[0] chooses the half, b[1]/b[2] the way within the lower/upper half.
  function automatic int plru_victim(input bit [2:0] b);
    int h;
    h = int'(b[0]);
    return 2 * h + (h != 0 ? int'(b[2]) : int'(b[1]));
  endfunction

  function automatic bit [2:0] plru_touch(input bit [2:0] b, input int w);
    bit [2:0] r;
    r = b;
    if (w < 2) begin
      r[0] = 1'b1;
      r[1] = (w == 0);
    end else begin
      r[0] = 1'b0;
      r[2] = (w == 2);
    end
    return r;
  endfunction

  // Datapath view of the current request.
  always_comb begin
    set_idx = 4'(cur_set);
    for (int i = 0; i < WAYS; i++) begin
      hit_vec[i]   = (dp_tag[cur_set][i] == cur_tag);
      valid_vec[i] = dp_valid[cur_set][i];
      dirty_vec[i] = dp_dirty[cur_set][i];
    end
  end

  // Memory: random completion delay while a request is up, occasional spurious pmem_resp otherwise.
  always @(posedge clk) begin
    #1;
    if (pmem_resp) pmem_resp = 1'b0;
    else if (pmem_read || pmem_write) begin
      if (mem_cnt <= 0) begin
        pmem_resp = mem_en;
        mem_cnt   = $urandom_range(0, 3);
      end else mem_cnt--;
    end else pmem_resp = mem_en && ($urandom_range(0, 7) == 0);
  end

  // Monitor and datapath update, mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_resp) begin
        check("resp_gap", int'(last_resp), 0);
        check("resp_pending", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          mon_e = expq.pop_front();
          check("resp_way", int'(way_sel), mon_e.way);
          check("resp_load_data", int'(load_data), int'(mon_e.wr));
          check("resp_set_dirty", int'(set_dirty), int'(mon_e.wr));
          check("writeback_seen", int'(saw_wb), int'(mon_e.wb));
          check("fill_seen", int'(saw_fill), int'(!mon_e.hit));
        end
        resp_seen = 1'b1;
        saw_wb    = 1'b0;
        saw_fill  = 1'b0;
      end else if (expq.size() > 0 && (pmem_read || pmem_write)) begin
        check("victim_way", int'(way_sel), expq[0].way);
        check("addr_sel_wb", int'(addr_sel_wb), int'(pmem_write));
        if (load_tag) check("fill_load_data", int'(load_data), 1);
        if (pmem_write) saw_wb = 1'b1;
        else saw_fill = 1'b1;
      end else if (!mem_read && !mem_write) begin
        check("idle_quiet", int'({mem_resp, pmem_read, pmem_write, load_tag, load_data,
                                  set_dirty, clr_dirty, addr_sel_wb}), 0);
      end
      last_resp = mem_resp;
      if (load_tag) begin
        dp_tag[cur_set][way_sel]   = cur_tag;
        dp_valid[cur_set][way_sel] = 1'b1;
        dp_dirty[cur_set][way_sel] = 1'b0;
      end
      if (set_dirty) dp_dirty[cur_set][way_sel] = 1'b1;
      if (clr_dirty) dp_dirty[cur_set][way_sel] = 1'b0;
    end
  end

  // One CPU transaction: model it, queue the expectation, hold the request until mem_resp.
  task automatic issue(input int s, input int tag, input bit wr, input bit clr);
    exp_t e;
    int   w;
    int   edges;
    bit   done;
    w = -1;
    for (int i = 0; i < WAYS; i++) if (w < 0 && m_valid[s][i] && m_tag[s][i] == tag) w = i;
    e.hit = (w >= 0);
    e.wr  = wr;
    e.wb  = 1'b0;
    if (e.hit) m_hit = (m_hit < MAXC) ? m_hit + 1 : MAXC;
    else begin
      m_miss = (m_miss < MAXC) ? m_miss + 1 : MAXC;
      for (int i = 0; i < WAYS; i++) if (w < 0 && !m_valid[s][i]) w = i;
      if (w < 0) w = plru_victim(m_plru[s]);
      e.wb = m_valid[s][w] && m_dirty[s][w];
      m_tag[s][w]   = tag;
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
    end
    if (wr) m_dirty[s][w] = 1'b1;
    e.way     = w;
    m_plru[s] = plru_touch(m_plru[s], w);
    if (clr) begin
      m_hit  = 0;
      m_miss = 0;
    end
    expq.push_back(e);
    cur_set   = s;
    cur_tag   = tag;
    mem_write = wr;
    mem_read  = !wr || ($urandom_range(0, 1) == 1);
    clr_cnt   = clr;
    edges = 0;
    done  = 1'b0;
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      if (resp_seen) done = 1'b1;
      #1;
      if (edges == 2) clr_cnt = 1'b0;
    end
    resp_seen = 1'b0;
    check("no_timeout", int'(done), 1);
    if (done && e.hit) check("hit_latency", edges, 2);
    check("hit_cnt", int'(hit_cnt), m_hit);
    check("miss_cnt", int'(miss_cnt), m_miss);
  endtask

  task automatic idle_gap(input int n);
    if (n > 0) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int dt_tag[12] = '{10, 11, 12, 12, 13, 11, 11, 10, 12, 13, 14, 15};
    bit dt_wr[12]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1};
    bit got;
    int ctag;
    for (int s = 0; s < SETS; s++) begin
      m_plru[s] = 3'b000;
      for (int w = 0; w < WAYS; w++) begin
        dp_tag[s][w]   = $urandom_range(0, 5);
        dp_valid[s][w] = 1'b0;
        dp_dirty[s][w] = 1'b0;
        m_tag[s][w]    = -1;
        m_valid[s][w]  = 1'b0;
        m_dirty[s][w]  = 1'b0;
      end
    end
    #3;
    check("rst_mem_resp", int'(mem_resp), 0);
    check("rst_pmem", int'({pmem_read, pmem_write}), 0);
    check("rst_strobes", int'({load_tag, load_data, set_dirty, clr_dirty, addr_sel_wb}), 0);
    check("rst_way_sel", int'(way_sel), 0);
    check("rst_hit_cnt", int'(hit_cnt), 0);
    check("rst_miss_cnt", int'(miss_cnt), 0);
    #9 rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset asserted while FILL is waiting on memory.
    cur_set  = 1;
    cur_tag  = 3;
    mem_read = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (pmem_read) got = 1'b1;
    end
    check("reach_fill", int'(got), 1);
    #2 rst = 1'b0;
    #1;
    check("rst_drops_pmem_read", int'(pmem_read), 0);
    check("rst_drops_strobes", int'({mem_resp, load_tag, load_data}), 0);
    mem_read = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_clears_miss_cnt", int'(miss_cnt), 0);
    mem_en = 1'b1;

    // Directed: clean fills, hit with one invalid way, lowest-invalid victim, write hits
    // (one back-to-back), then a miss with every way dirty.
    for (int i = 0; i < 12; i++) begin
      issue(0, dt_tag[i], dt_wr[i], 1'b0);
      idle_gap(i == 5 ? 0 : $urandom_range(0, 2));
    end

    // Random traffic over a few sets and a small tag pool; counters saturate early.
    repeat (150) begin
      issue($urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 1) == 1, 1'b0);
      idle_gap($urandom_range(0, 2));
    end

    // Counter clear coinciding with a hit increment.
    ctag = -1;
    for (int w = 0; w < WAYS; w++) if (ctag < 0 && m_valid[0][w]) ctag = m_tag[0][w];
    issue(0, ctag, 1'b0, 1'b1);
    idle_gap(2);

    check("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
